idma_obi_ctrl_mux: RTL
======================

IDMA_OBI_CTRL_MUX -- requirements
Module: idma_obi_ctrl_mux

Interface
REQ-001 Parameter obi_req_t, default magia_tile_pkg::core_obi_data_req_t, OBI request type.
REQ-002 Parameter obi_rsp_t, default magia_tile_pkg::core_obi_data_rsp_t, OBI response type.
REQ-003 Parameter idma_fe_reg_req_t / idma_fe_reg_rsp_t, default magia_tile_pkg types, iDMA register-frontend request/response.
REQ-004 Parameter NUM_CH, default 2, number of iDMA frontends; legal values are 1 to 8.
REQ-005 Parameter CH_SEL_OFF, default 9, LSB of the channel-select address field; CH_SEL_OFF >= 9 and CH_SEL_OFF + CH_W <= 12, where CH_W = max(1, clog2(NUM_CH)).
REQ-006 Parameter BASE_ADDR, default magia_tile_pkg::IDMA_CTRL_ADDR_START, block base address.
REQ-007 Parameter TIMEOUT, default 255, number of cycles to wait for frontend ready; legal values are 1 to 65535.
REQ-008 Ports: clk_i input 1 clock; rst_ni input 1 asynchronous active-low reset.
REQ-009 Ports: obi_req_i input obi_req_t CPU request; obi_rsp_o output obi_rsp_t CPU response.
REQ-010 Ports: idma_req_o output [NUM_CH] idma_fe_reg_req_t; idma_rsp_i input [NUM_CH] idma_fe_reg_rsp_t.
REQ-011 Ports: busy_o output 1, set while a transaction is in flight; timeout_o output 1, a one-cycle pulse on timeout.

Function
REQ-012 Decode offset as (addr[11:0] - BASE_ADDR[11:0]) with bits [CH_SEL_OFF+CH_W-1:CH_SEL_OFF] cleared; channel = addr[CH_SEL_OFF+CH_W-1:CH_SEL_OFF].
REQ-013 An access is valid only if all of the following hold:
- offset is 0x0, or word-aligned in 0x4..0xC0, or one of 0xD0, 0xD8, 0xE0, 0xE8, 0xF0, 0xF8, 0x100, 0x108, 0x110;
- channel < NUM_CH.
REQ-014 The state machine has three states: IDLE, FWD, RSP; the reset state is IDLE.
REQ-015 obi_rsp_o.gnt = obi_req_i.req while in IDLE; it is 0 in every other state.
REQ-016 On a grant, latch offset, channel, we, wdata, be, aid and the valid flag. Next state is FWD if the access is valid, RSP with err=1 if not.
REQ-017 In FWD, drive idma_req_o[ch] as follows; all other channels get '0:
- addr = {20'h0, offset};
- write, wdata, wstrb from the latched request;
- valid = 1.
REQ-018 Request fields SHALL stay stable while valid=1 and ready=0.
REQ-019 In FWD, when idma_rsp_i[ch].ready = 1, capture rdata and error, drop valid in the next cycle, and go to RSP.
REQ-020 A 16-bit wait counter clears on entry to FWD and increments each FWD cycle without ready. When it reaches TIMEOUT:
- drop valid;
- pulse timeout_o for one cycle;
- go to RSP with err=1 and rdata=0.
REQ-021 In RSP, assert obi_rsp_o.rvalid for exactly one cycle with the following fields, then return to IDLE:
- r.rdata = captured rdata (0 for writes, invalid accesses and timeouts);
- r.err = captured error OR invalid OR timeout;
- r.rid = latched aid;
- r.r_optional = '0.
REQ-022 Latency: rvalid is 1 cycle after gnt for an invalid access, and k+1 cycles after gnt when ready arrives k cycles after gnt (k >= 1). The minimum is 2 cycles.
REQ-023 At most one transaction is outstanding. A new request presented during the RSP cycle is granted in the following IDLE cycle.
REQ-024 If ready and the timeout condition occur in the same cycle, ready wins: the response is normal and there is no timeout pulse.
REQ-025 Readiness on non-selected channels is ignored.
REQ-026 busy_o = 1 in FWD and RSP, 0 in IDLE.
REQ-027 With NUM_CH=1, the channel field is still decoded with CH_W=1; channel 1 is invalid.

Reset
REQ-028 Asynchronous assertion of rst_ni forces the following immediately, independent of clk_i:
- state = IDLE;
- wait counter = 0;
- all latched fields = 0;
- gnt=0, rvalid=0, rdata=0, err=0, rid=0;
- all idma_req_o = '0;
- busy_o=0, timeout_o=0.
REQ-029 Reset during FWD abandons the transaction: no rvalid follows. Frontend valid drops with reset, and the first request after deassertion is handled normally.
REQ-030 Reset deassertion takes effect on the next rising clk_i edge.

Verification
REQ-031 Write to BASE+0xD0, channel 1, wdata 0xCAFE0000, ready on the first FWD cycle:
- gnt in cycle 0;
- idma_req_o[1].valid in cycle 1 with addr 0xD0;
- rvalid in cycle 2 with err=0.
REQ-032 Read from BASE+0x44, channel 0, ready after 3 cycles with rdata 0x5:
- rvalid 4 cycles after gnt with rdata 0x5;
- idma_req_o[1] stays '0 throughout.
REQ-033 Access to offset 0xD4 (invalid), then channel 3 with NUM_CH=2:
- each gets rvalid 1 cycle after gnt with err=1;
- no frontend valid is ever raised.
REQ-034 TIMEOUT=4, ready never asserted:
- valid is held for 4 cycles;
- timeout_o pulses once;
- rvalid follows with err=1 and rdata=0.
REQ-035 Back-to-back reads with aid 3 then aid 7:
- the second gnt occurs only after the first rvalid;
- the responses return rid 3 then rid 7.
REQ-036 rst_ni asserted mid-FWD:
- all outputs are 0 immediately;
- no rvalid follows;
- the next access completes normally.

Source files
------------

// File: rtl/magia_tile_pkg.sv
// Tile-level OBI and iDMA register-frontend types consumed by the iDMA control mux.
// Only the subset of the tile package that the mux depends on.
package magia_tile_pkg;

  localparam int unsigned OBI_ID_W = 5;
  localparam logic [31:0] IDMA_CTRL_ADDR_START = 32'h0001_0000;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [OBI_ID_W-1:0] aid;
    logic                a_optional;
  } core_obi_data_a_chan_t;

  typedef struct packed {
    logic                  req;
    core_obi_data_a_chan_t a;
  } core_obi_data_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [OBI_ID_W-1:0] rid;
    logic                err;
    logic                r_optional;
  } core_obi_data_r_chan_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    core_obi_data_r_chan_t r;
  } core_obi_data_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } idma_fe_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } idma_fe_reg_rsp_t;

endpackage

// File: rtl/idma_obi_ctrl_mux.sv
// Routes single outstanding OBI accesses from the core to one of NUM_CH iDMA register
// frontends, selected by an address field, with offset filtering and a ready timeout.
module idma_obi_ctrl_mux #(
  parameter type         obi_req_t         = magia_tile_pkg::core_obi_data_req_t,
  parameter type         obi_rsp_t         = magia_tile_pkg::core_obi_data_rsp_t,
  parameter type         idma_fe_reg_req_t = magia_tile_pkg::idma_fe_reg_req_t,
  parameter type         idma_fe_reg_rsp_t = magia_tile_pkg::idma_fe_reg_rsp_t,
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned CH_SEL_OFF        = 9,
  parameter logic [31:0] BASE_ADDR         = magia_tile_pkg::IDMA_CTRL_ADDR_START,
  parameter int unsigned TIMEOUT           = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         obi_req_i,
  output obi_rsp_t         obi_rsp_o,
  output idma_fe_reg_req_t idma_req_o [NUM_CH],
  input  idma_fe_reg_rsp_t idma_rsp_i [NUM_CH],
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ID_W    = magia_tile_pkg::OBI_ID_W;
  localparam logic [11:0] CH_MASK = 12'(((1 << CH_W) - 1) << CH_SEL_OFF);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StFwd, StRsp} state_e;

  state_e state_q, state_d;

  logic [11:0]     off_q;
  logic [CH_W-1:0] ch_q;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [ID_W-1:0] aid_q;
  logic            acc_ok_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [15:0]     wait_cnt_q;
  logic            timeout_q;
  // Holds off grants until the first clock edge after reset release.
  logic            live_q;

  // Address decode of the incoming request.
  logic [11:0]     off_raw, off_dec;
  logic [CH_W-1:0] ch_dec;
  logic            off_ok, ch_ok, acc_ok;

  assign off_raw = obi_req_i.a.addr[11:0] - BASE_ADDR[11:0];
  assign off_dec = off_raw & ~CH_MASK;
  assign ch_dec  = obi_req_i.a.addr[CH_SEL_OFF +: CH_W];
  assign ch_ok   = 32'(ch_dec) < NUM_CH;
  assign acc_ok  = off_ok && ch_ok;

  always_comb begin
    case (off_dec)
      12'h0D0, 12'h0D8, 12'h0E0, 12'h0E8, 12'h0F0,
      12'h0F8, 12'h100, 12'h108, 12'h110: off_ok = 1'b1;
      default: off_ok = (off_dec[1:0] == 2'b00) && (off_dec <= 12'h0C0);
    endcase
  end

  logic        unused_req;
  assign unused_req = ^{obi_req_i.a.addr[31:12], obi_req_i.a.a_optional};

  // Response of the latched channel; other channels are never looked at.
  logic        sel_ready, sel_error;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_error = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_ready = idma_rsp_i[i].ready;
        sel_error = idma_rsp_i[i].error;
        sel_rdata = idma_rsp_i[i].rdata;
      end
    end
  end

  logic grant, fwd_done, fwd_tmo;

  assign grant    = obi_req_i.req && (state_q == StIdle) && live_q;
  assign fwd_done = (state_q == StFwd) && sel_ready;
  // Ready in the same cycle as the timeout wins.
  assign fwd_tmo  = (state_q == StFwd) && !sel_ready && (wait_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = acc_ok ? StFwd : StRsp;
      end
      StFwd: begin
        if (fwd_done || fwd_tmo) state_d = StRsp;
      end
      StRsp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q      <= '0;
      ch_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      aid_q      <= '0;
      acc_ok_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      timeout_q <= fwd_tmo;
      if (grant) begin
        off_q      <= off_dec;
        ch_q       <= ch_dec;
        we_q       <= obi_req_i.a.we;
        wdata_q    <= obi_req_i.a.wdata;
        be_q       <= obi_req_i.a.be;
        aid_q      <= obi_req_i.a.aid;
        acc_ok_q   <= acc_ok;
        rdata_q    <= '0;
        err_q      <= 1'b0;
        wait_cnt_q <= '0;
      end else if (state_q == StFwd) begin
        if (sel_ready) begin
          rdata_q <= we_q ? '0 : sel_rdata;
          err_q   <= sel_error;
        end else if (!fwd_tmo) begin
          wait_cnt_q <= wait_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    obi_rsp_o     = '0;
    obi_rsp_o.gnt = grant;
    if (state_q == StRsp) begin
      obi_rsp_o.rvalid  = 1'b1;
      obi_rsp_o.r.rdata = rdata_q;
      obi_rsp_o.r.err   = err_q | ~acc_ok_q | timeout_q;
      obi_rsp_o.r.rid   = aid_q;
    end
    busy_o    = (state_q != StIdle);
    timeout_o = timeout_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idma_req_o[i] = '0;
      if ((state_q == StFwd) && (ch_q == CH_W'(i))) begin
        idma_req_o[i].addr  = {20'h0, off_q};
        idma_req_o[i].write = we_q;
        idma_req_o[i].wdata = wdata_q;
        idma_req_o[i].wstrb = be_q;
        idma_req_o[i].valid = 1'b1;
      end
    end
  end

endmodule
